// File: rtl/wb_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_sequencer_if
// Purpose  : Bundles the result-pipe handshake and write-back bus of the
//            write-back sequencer. The slave modport is the sequencer's view.
//            Optional macro WB_SEQ_LAST_EN adds the O_WB_Last signal.
// Revision : 1.0  initial release
// ============================================================================
interface wb_sequencer_if #(
    parameter int WIDTH_INDEX = 8,
    parameter int WIDTH_DATA  = 32
);
    logic                   I_Stall;
    logic                   I_Req;
    logic [WIDTH_INDEX-1:0] I_Dst;
    logic [WIDTH_INDEX-1:0] I_Slice_Len;
    logic [WIDTH_DATA-1:0]  I_Data;
    logic                   O_WB_Valid;
    logic [WIDTH_INDEX-1:0] O_WB_Index;
    logic [WIDTH_DATA-1:0]  O_WB_Data;
    logic                   O_Full;
    logic                   O_Busy;
`ifdef WB_SEQ_LAST_EN
    logic                   O_WB_Last;
`endif

    modport slave (
        input  I_Stall,
        input  I_Req,
        input  I_Dst,
        input  I_Slice_Len,
        input  I_Data,
        output O_WB_Valid,
        output O_WB_Index,
        output O_WB_Data,
        output O_Full,
        output O_Busy
`ifdef WB_SEQ_LAST_EN
        , output O_WB_Last
`endif
    );

    modport master (
        output I_Stall,
        output I_Req,
        output I_Dst,
        output I_Slice_Len,
        output I_Data,
        input  O_WB_Valid,
        input  O_WB_Index,
        input  O_WB_Data,
        input  O_Full,
        input  O_Busy
`ifdef WB_SEQ_LAST_EN
        , input O_WB_Last
`endif
    );
endinterface
`default_nettype wire

// File: rtl/wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wb_sequencer
// Purpose  : Expands result slices from the execution pipe into a stream of
//            write-backs with consecutive (wrapping) destination indices,
//            buffered through a DEPTH-entry FIFO that the consumer drains
//            whenever it is not stalled.
//            Optional macro WB_SEQ_LAST_EN stores and presents a per-entry
//            end-of-slice flag on O_WB_Last.
// Revision : 1.0  initial release
// ============================================================================
module wb_sequencer #(
    parameter int DEPTH       = 4,
    parameter int WIDTH_INDEX = 8,
    parameter int WIDTH_DATA  = 32
) (
    input  wire logic     clock,
    input  wire logic     reset,
    wb_sequencer_if.slave bus
);
    localparam int                c_ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ADDR_W:0] c_DEPTH_CNT = (c_ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q,  state_d;
    logic [WIDTH_INDEX-1:0] base_q,   base_d;
    logic [WIDTH_INDEX-1:0] len_q,    len_d;
    logic [WIDTH_INDEX-1:0] cnt_q,    cnt_d;
    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [c_ADDR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [c_ADDR_W:0]      rd_ptr_q, rd_ptr_d;

    logic [WIDTH_INDEX-1:0] idx_mem  [DEPTH];
    logic [WIDTH_DATA-1:0]  data_mem [DEPTH];
`ifdef WB_SEQ_LAST_EN
    logic                   last_mem [DEPTH];
    logic                   w_push_last;
`endif

    logic [c_ADDR_W:0]      w_occupancy;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_accept;
    logic                   w_pop;
    logic [WIDTH_INDEX-1:0] w_push_idx;
    logic [c_ADDR_W-1:0]    w_wr_addr;
    logic [c_ADDR_W-1:0]    w_rd_addr;

    // Occupancy and flags come only from registered pointers, so O_Full has
    // no combinational path from I_Req.
    assign w_occupancy = wr_ptr_q - rd_ptr_q;
    assign w_empty     = (w_occupancy == '0);
    assign w_full      = (w_occupancy == c_DEPTH_CNT);
    assign w_accept    = bus.I_Req & ~w_full;
    assign w_pop       = ~w_empty & ~bus.I_Stall;
    assign w_wr_addr   = wr_ptr_q[c_ADDR_W-1:0];
    assign w_rd_addr   = rd_ptr_q[c_ADDR_W-1:0];

    // Slice sequencing: pick the pushed index and advance the slice counter.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        w_push_idx = '0;
`ifdef WB_SEQ_LAST_EN
        w_push_last = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    base_d     = bus.I_Dst;
                    len_d      = bus.I_Slice_Len;
                    cnt_d      = WIDTH_INDEX'(1);
                    w_push_idx = bus.I_Dst;
`ifdef WB_SEQ_LAST_EN
                    w_push_last = (bus.I_Slice_Len == '0);
`endif
                    if (bus.I_Slice_Len != '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (w_accept) begin
                    // Natural WIDTH_INDEX-bit overflow gives the index wrap.
                    w_push_idx = base_q + cnt_q;
                    cnt_d      = cnt_q + WIDTH_INDEX'(1);
`ifdef WB_SEQ_LAST_EN
                    w_push_last = (cnt_q == len_q);
`endif
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer advance on push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + (c_ADDR_W + 1)'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + (c_ADDR_W + 1)'(1);
        end
    end

    // Control state register; reset abandons any slice and empties the FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only observed behind a valid pointer range.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            idx_mem[w_wr_addr]  <= w_push_idx;
            data_mem[w_wr_addr] <= bus.I_Data;
`ifdef WB_SEQ_LAST_EN
            last_mem[w_wr_addr] <= w_push_last;
`endif
        end
    end

    // Head of FIFO drives the write-back bus, forced to zero when not valid.
    assign bus.O_WB_Valid = w_pop;
    assign bus.O_WB_Index = w_pop ? idx_mem[w_rd_addr]  : '0;
    assign bus.O_WB_Data  = w_pop ? data_mem[w_rd_addr] : '0;
`ifdef WB_SEQ_LAST_EN
    assign bus.O_WB_Last  = w_pop ? last_mem[w_rd_addr] : 1'b0;
`endif
    assign bus.O_Full     = w_full;
    assign bus.O_Busy     = (state_q == RUN) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_sequencer
// Purpose  : Directed self-checking bench for wb_sequencer. Expected
//            write-backs are queued when stimulus is driven and compared as
//            the DUT presents them. Honours WB_SEQ_LAST_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_sequencer;
    typedef struct {
        logic [7:0]  idx;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   sent;
    exp_t sb[$];

    wb_sequencer_if #(.WIDTH_INDEX(8), .WIDTH_DATA(32)) bus ();

    wb_sequencer #(
        .DEPTH       (4),
        .WIDTH_INDEX (8),
        .WIDTH_DATA  (32)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare whatever the write-back bus shows against the scoreboard head.
    task automatic monitor();
        exp_t e;
        if (bus.O_WB_Valid === 1'b1) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL wb_unexpected: observed index %0h data %0h expected no write-back",
                       bus.O_WB_Index, bus.O_WB_Data);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wb_index", 64'(bus.O_WB_Index), 64'(e.idx));
                chk("wb_data",  64'(bus.O_WB_Data),  64'(e.data));
`ifdef WB_SEQ_LAST_EN
                chk("wb_last",  64'(bus.O_WB_Last),  64'(e.last));
`endif
            end
        end else begin
            chk("idle_index", 64'(bus.O_WB_Index), 64'd0);
            chk("idle_data",  64'(bus.O_WB_Data),  64'd0);
`ifdef WB_SEQ_LAST_EN
            chk("idle_last",  64'(bus.O_WB_Last),  64'd0);
`endif
        end
    endtask

    // One clock: check outputs at the falling edge, return just after rising.
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        bus.I_Stall     = 1'b0;
        bus.I_Req       = 1'b0;
        bus.I_Dst       = '0;
        bus.I_Slice_Len = '0;
        bus.I_Data      = '0;

        // Reset state
        #1;
        chk("rst_valid", 64'(bus.O_WB_Valid), 64'd0);
        chk("rst_full",  64'(bus.O_Full),     64'd0);
        chk("rst_busy",  64'(bus.O_Busy),     64'd0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_busy", 64'(bus.O_Busy), 64'd0);

        // Single-element slice, one-cycle latency, busy drops after it
        bus.I_Req = 1'b1; bus.I_Dst = 8'h10; bus.I_Slice_Len = 8'd0; bus.I_Data = 32'hA5;
        sb.push_back('{idx: 8'h10, data: 32'hA5, last: 1'b1});
        cycle();
        bus.I_Req = 1'b0;
        chk("single_latency_valid", 64'(bus.O_WB_Valid), 64'd1);
        chk("single_busy",          64'(bus.O_Busy),     64'd1);
        cycle();
        chk("single_busy_drop", 64'(bus.O_Busy),   64'd0);
        chk("single_drained",   64'(sb.size()),    64'd0);

        // Four-element slice; later I_Dst/I_Slice_Len must be ignored
        bus.I_Dst = 8'h20; bus.I_Slice_Len = 8'd3;
        for (int i = 0; i < 4; i++) begin
            bus.I_Req  = 1'b1;
            bus.I_Data = 32'(i + 1);
            if (i > 0) begin
                bus.I_Dst = 8'h77; bus.I_Slice_Len = 8'd9;
            end
            sb.push_back('{idx: 8'(8'h20 + i), data: 32'(i + 1), last: (i == 3)});
            cycle();
        end
        bus.I_Req = 1'b0;
        chk("slice4_busy", 64'(bus.O_Busy), 64'd1);
        cycle();
        chk("slice4_drained", 64'(sb.size()),   64'd0);
        chk("slice4_idle",    64'(bus.O_Busy),  64'd0);

        // Stall held: four accepted, fifth discarded while full
        bus.I_Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.I_Req = 1'b1; bus.I_Dst = 8'(8'h30 + i); bus.I_Slice_Len = 8'd0;
            bus.I_Data = 32'(32'h100 + i);
            if (i < 4) begin
                sb.push_back('{idx: 8'(8'h30 + i), data: 32'(32'h100 + i), last: 1'b1});
            end
            cycle();
            if (i == 3) begin
                chk("stall_full_after4", 64'(bus.O_Full), 64'd1);
            end
        end
        bus.I_Req = 1'b0;
        chk("stall_full_held", 64'(bus.O_Full),  64'd1);
        chk("stall_busy",      64'(bus.O_Busy),  64'd1);
        bus.I_Stall = 1'b0;
        cycle();
        chk("stall_full_release", 64'(bus.O_Full), 64'd0);
        cycle();
        cycle();
        cycle();
        chk("stall_drained",  64'(sb.size()),       64'd0);
        chk("stall_no_extra", 64'(bus.O_WB_Valid),  64'd0);
        cycle();

        // Index wrap across 0xFF
        bus.I_Dst = 8'hFE; bus.I_Slice_Len = 8'd3;
        for (int i = 0; i < 4; i++) begin
            bus.I_Req  = 1'b1;
            bus.I_Data = 32'(32'hD0 + i);
            sb.push_back('{idx: 8'(8'hFE + i), data: 32'(32'hD0 + i), last: (i == 3)});
            cycle();
        end
        bus.I_Req = 1'b0;
        cycle();
        chk("wrap_drained", 64'(sb.size()), 64'd0);

        // Reset mid-slice after two of four elements
        bus.I_Dst = 8'h40; bus.I_Slice_Len = 8'd3;
        bus.I_Req = 1'b1; bus.I_Data = 32'hE0;
        sb.push_back('{idx: 8'h40, data: 32'hE0, last: 1'b0});
        cycle();
        bus.I_Data = 32'hE1;
        sb.push_back('{idx: 8'h41, data: 32'hE1, last: 1'b0});
        cycle();
        bus.I_Req = 1'b0;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("midrst_valid", 64'(bus.O_WB_Valid), 64'd0);
        chk("midrst_index", 64'(bus.O_WB_Index), 64'd0);
        chk("midrst_data",  64'(bus.O_WB_Data),  64'd0);
        chk("midrst_busy",  64'(bus.O_Busy),     64'd0);
        chk("midrst_full",  64'(bus.O_Full),     64'd0);
        cycle();
        rst = 1'b0;
        bus.I_Req = 1'b1; bus.I_Dst = 8'h50; bus.I_Slice_Len = 8'd0; bus.I_Data = 32'hBEEF;
        sb.push_back('{idx: 8'h50, data: 32'hBEEF, last: 1'b1});
        cycle();
        bus.I_Req = 1'b0;
        cycle();
        chk("midrst_new_slice", 64'(sb.size()), 64'd0);
        chk("midrst_idle",      64'(bus.O_Busy), 64'd0);

        // Eight-element slice with stall toggling every cycle
        bus.I_Dst = 8'h60; bus.I_Slice_Len = 8'd7;
        sent = 0;
        for (int i = 0; i < 40; i++) begin
            bus.I_Stall = i[0];
            if (sent < 8 && bus.O_Full == 1'b0) begin
                bus.I_Req  = 1'b1;
                bus.I_Data = 32'(32'hC0 + sent);
                sb.push_back('{idx: 8'(8'h60 + sent), data: 32'(32'hC0 + sent), last: (sent == 7)});
                sent++;
            end else begin
                bus.I_Req = 1'b0;
            end
            cycle();
        end
        bus.I_Req   = 1'b0;
        bus.I_Stall = 1'b0;
        cycle();
        chk("toggle_sent",    64'(sent),          64'd8);
        chk("toggle_drained", 64'(sb.size()),     64'd0);
        chk("toggle_idle",    64'(bus.O_Busy),    64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: result FIFO entries (power of two, >=2).
REQ-002 Parameter WIDTH_INDEX, default 8: write-back register index width.
REQ-003 Parameter WIDTH_DATA, default 32: write-back data width.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 I_Stall  in  1  consumer stall; no write-back leaves while high.
REQ-007 I_Req  in  1  result element valid from execution pipe.
REQ-008 I_Dst  in  WIDTH_INDEX  base destination index; sampled only on first element of a slice.
REQ-009 I_Slice_Len  in  WIDTH_INDEX  extra elements after the first; sampled with I_Dst.
REQ-010 I_Data  in  WIDTH_DATA  result data.
REQ-011 O_WB_Valid  out  1  write-back index/data valid this cycle.
REQ-012 O_WB_Index  out  WIDTH_INDEX  write-back destination index.
REQ-013 O_WB_Data  out  WIDTH_DATA  write-back data.
REQ-014 O_Full  out  1  FIFO holds DEPTH entries; upstream must not assert I_Req.
REQ-015 O_Busy  out  1  slice in progress or FIFO non-empty.

Function
REQ-016 Accept = I_Req & ~O_Full; an I_Req while O_Full SHALL be discarded with no state change.
REQ-017 FSM states IDLE, RUN; reset state IDLE.
REQ-018 IDLE + Accept: push {I_Dst, I_Data}; latch Base=I_Dst, Len=I_Slice_Len, Cnt=1; go RUN if I_Slice_Len!=0, else stay IDLE.
REQ-019 RUN + Accept: push {Base+Cnt mod 2^WIDTH_INDEX, I_Data}, I_Dst/I_Slice_Len ignored; Cnt++; if Cnt==Len return IDLE.
REQ-020 Index arithmetic SHALL wrap modulo 2^WIDTH_INDEX (Base=0xFE, Len=3 -> 0xFE,0xFF,0x00,0x01).
REQ-021 Slice of I_Slice_Len=N SHALL produce exactly N+1 write-backs with consecutive indices.
REQ-022 Pop when FIFO non-empty & ~I_Stall; O_WB_Valid = non-empty & ~I_Stall, index/data = FIFO head.
REQ-023 O_WB_Index and O_WB_Data SHALL be zero whenever O_WB_Valid is low.
REQ-024 Latency: element accepted at edge t SHALL be presented no earlier than cycle after t; empty FIFO, no stall -> exactly 1 cycle.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged; ordering strictly FIFO, pointers wrap at DEPTH.
REQ-026 O_Full = (occupancy==DEPTH), registered-state derived, no combinational path from I_Req.
REQ-027 I_Stall SHALL NOT block accepts; only O_Full blocks.
REQ-028 O_Busy = (state==RUN) | non-empty.

Reset
REQ-029 reset asserted at any time (including mid-slice) SHALL immediately force IDLE, empty FIFO, Cnt=0, Base=0, Len=0.
REQ-030 During and after reset until next push: O_WB_Valid=0, O_WB_Index=0, O_WB_Data=0, O_Full=0, O_Busy=0.

Configuration
REQ-031 Macro WB_SEQ_LAST_EN defined: extra output O_WB_Last (1 bit) stored per FIFO entry, high with the final element of each slice (including N=0 slices), zero when O_WB_Valid low.
REQ-032 WB_SEQ_LAST_EN undefined: O_WB_Last port and its storage absent; all other behaviour identical.

Verification
REQ-033 I_Dst=0x10, I_Slice_Len=0, I_Data=0xA5, no stall -> one cycle later single write-back idx 0x10 data 0xA5; O_Busy drops next cycle.
REQ-034 I_Dst=0x20, Len=3, data 1..4 on consecutive cycles -> write-backs idx 0x20..0x23 data 1..4, one per cycle, last flagged when WB_SEQ_LAST_EN.
REQ-035 I_Stall held high, 5 requests with DEPTH=4 -> O_Full after 4th, 5th discarded; release stall -> exactly 4 write-backs in order.
REQ-036 Base=0xFE, Len=3 -> indices 0xFE,0xFF,0x00,0x01.
REQ-037 Reset asserted after 2 of 4 slice elements -> outputs zero immediately; next I_Req treated as new slice using its I_Dst.
REQ-038 Alternating I_Stall every cycle during Len=7 slice -> all 8 write-backs delivered in order, none duplicated or lost.
